// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the issue controller: FSM states, stall vectors, register index width.
package issue_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HAZ = 2'd1,
    ST_EXS = 2'd2,
    ST_FLS = 2'd3
  } issue_state_e;

  // Hold vector bit order: {wb, mem, ex, id, if, pc}
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_HAZ  = 6'b000111;
  localparam logic [5:0] STALL_EXS  = 6'b001111;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode/writeback/execute signals into the issue controller and its stall/issue/status outputs.
interface issue_ctrl_if #(parameter int NREG = 32);
  import issue_ctrl_pkg::*;

  // Not a valid/ready channel: id_valid_i qualifies the decode fields each cycle, and the
  // instruction advances only in a cycle where issue_o is high; otherwise decode holds it.
  logic              id_valid_i;
  logic              reg1_read_i;
  logic              reg2_read_i;
  logic [REG_AW-1:0] reg1_addr_i;
  logic [REG_AW-1:0] reg2_addr_i;
  logic              wreg_i;
  logic [REG_AW-1:0] wd_i;
  logic              long_lat_i;
  logic              wb_we_i;
  logic [REG_AW-1:0] wb_addr_i;
  logic              ex_stallreq_i;
  logic              flush_i;

  logic [5:0]        stall_o;
  logic              issue_o;
  logic [NREG-1:0]   busy_o;
  logic [15:0]       stall_cnt_o;
  logic              deadlock_o;
  issue_state_e      state_o;

  modport master (
    output id_valid_i, reg1_read_i, reg2_read_i, reg1_addr_i, reg2_addr_i,
           wreg_i, wd_i, long_lat_i, wb_we_i, wb_addr_i, ex_stallreq_i, flush_i,
    input  stall_o, issue_o, busy_o, stall_cnt_o, deadlock_o, state_o
  );

  modport slave (
    input  id_valid_i, reg1_read_i, reg2_read_i, reg1_addr_i, reg2_addr_i,
           wreg_i, wd_i, long_lat_i, wb_we_i, wb_addr_i, ex_stallreq_i, flush_i,
    output stall_o, issue_o, busy_o, stall_cnt_o, deadlock_o, state_o
  );

endinterface

// File: rtl/issue_ctrl_sb_regs.sv
// Pending-write scoreboard: one bit per register, set on long-latency issue, cleared on writeback.
module issue_ctrl_sb_regs
  import issue_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set_en,
  input  logic [REG_AW-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [REG_AW-1:0] i_clr_addr,
  output logic [NREG-1:0]   o_busy,
  output logic [NREG-1:0]   o_eb
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_vec;
  logic [NREG-1:0] w_clr_vec;

  // Bit 0 is excluded from both vectors so register 0 can never appear busy.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    for (int i = 1; i < NREG; i++) begin
      w_set_vec[i] = i_set_en && (i_set_addr == REG_AW'(i));
      w_clr_vec[i] = i_clr_en && (i_clr_addr == REG_AW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
    end
  end

  assign o_busy = r_busy;
  // A writeback landing this cycle already resolves the hazard for readers.
  assign o_eb   = r_busy & ~w_clr_vec;

endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage issue controller: hazard detection against a load scoreboard, stall priority,
// stall statistics and a sticky deadlock flag.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  issue_ctrl_if.slave bus
);

  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_eb;
  logic            w_r1_busy;
  logic            w_r2_busy;
  logic            w_wd_busy;
  logic            w_hazard;
  logic            w_set_en;
  logic            w_stalled;
  logic [5:0]      w_stall;
  logic            w_issue;
  issue_state_e    w_state_nxt;
  issue_state_e    r_state;
  logic [15:0]     r_stall_cnt;
  logic [7:0]      r_cons;
  logic            r_deadlock;

  issue_ctrl_sb_regs #(.NREG(NREG)) u_sb_regs (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_set_en),
    .i_set_addr (bus.wd_i),
    .i_clr_en   (bus.wb_we_i),
    .i_clr_addr (bus.wb_addr_i),
    .o_busy     (w_busy),
    .o_eb       (w_eb)
  );

  always_comb begin
    w_r1_busy = 1'b0;
    w_r2_busy = 1'b0;
    w_wd_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.reg1_addr_i == REG_AW'(i)) w_r1_busy = w_eb[i];
      if (bus.reg2_addr_i == REG_AW'(i)) w_r2_busy = w_eb[i];
      if (bus.wd_i        == REG_AW'(i)) w_wd_busy = w_eb[i];
    end
  end

  assign w_hazard = bus.id_valid_i && ((bus.reg1_read_i && w_r1_busy) ||
                                       (bus.reg2_read_i && w_r2_busy) ||
                                       (bus.wreg_i      && w_wd_busy));

  // Outputs depend only on inputs and scoreboard; r_state is bookkeeping, not a stall source.
  always_comb begin
    w_stall     = STALL_NONE;
    w_issue     = 1'b0;
    w_stalled   = 1'b0;
    w_state_nxt = ST_RUN;
    if (bus.flush_i) begin
      w_state_nxt = ST_FLS;
    end else if (bus.ex_stallreq_i) begin
      w_stall     = STALL_EXS;
      w_stalled   = 1'b1;
      w_state_nxt = ST_EXS;
    end else if (w_hazard) begin
      w_stall     = STALL_HAZ;
      w_stalled   = 1'b1;
      w_state_nxt = ST_HAZ;
    end else begin
      w_issue     = bus.id_valid_i;
    end
  end

  assign w_set_en = w_issue && bus.wreg_i && bus.long_lat_i && (bus.wd_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_cons      <= '0;
      r_deadlock  <= 1'b0;
    end else begin
      if (w_stalled && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_stalled) begin
        if (r_cons != 8'hFF) r_cons <= r_cons + 8'd1;
        if ((int'(r_cons) + 1) >= TIMEOUT) r_deadlock <= 1'b1;
      end else begin
        r_cons <= '0;
      end
    end
  end

  assign bus.stall_o     = w_stall;
  assign bus.issue_o     = w_issue;
  assign bus.busy_o      = w_busy;
  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.deadlock_o  = r_deadlock;
  assign bus.state_o     = r_state;

endmodule
